// File: rtl/cache_pkg.sv
// Shared encodings for the MSI snoop path: line states, bus operations,
// snoop FSM state codes and default widths.
package cache_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 4;
  localparam int STAT_W_DEF = 8;

  // MSI line state as stored in the line register; 2'b11 is never legal
  typedef enum logic [1:0] {
    LINE_INVALID  = 2'b00,
    LINE_SHARED   = 2'b01,
    LINE_MODIFIED = 2'b10,
    LINE_ILLEGAL  = 2'b11
  } line_state_e;

  // Snoop bus operation codes
  typedef enum logic [1:0] {
    OP_NONE       = 2'b00,
    OP_READ_MISS  = 2'b01,
    OP_WRITE_MISS = 2'b10,
    OP_INVALIDATE = 2'b11
  } bus_op_e;

  // Snoop FSM state codes
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOOKUP    = 3'd1;
  localparam logic [2:0] ST_WRITEBACK = 3'd2;
  localparam logic [2:0] ST_UPDATE    = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] value_q, value_d;

  // Next count: clear wins, otherwise increment unless already saturated
  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = '0;
    end else if (inc && (value_q != MAX)) begin
      value_d = value_q + ONE;
    end
  end

  // Counter register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/snoop_responder.sv
// Bus-side snoop controller for a single MSI cache line. Looks up the line
// on each snooped request, writes back Modified data to memory when needed,
// then rewrites the line state through the line write port.
// Optional SNOOP_STATS_EN adds saturating hit/flush counters.
module snoop_responder
  import cache_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int STAT_W = STAT_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              bus_valid,
  input  logic [1:0]        bus_op,
  input  logic [ADDR_W-1:0] bus_address,
  output logic              bus_ready,
  output logic              bus_done,
  output logic              bus_hit,
  output logic              bus_flush,
  input  logic [1:0]        line_state,
  input  logic [ADDR_W-1:0] line_address,
  input  logic [DATA_W-1:0] line_data,
  output logic              line_write,
  output logic [1:0]        line_state_out,
  output logic [ADDR_W-1:0] line_address_out,
  output logic [DATA_W-1:0] line_data_out,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  input  logic              mem_ack,
`ifdef SNOOP_STATS_EN
  output logic [STAT_W-1:0] stat_hits,
  output logic [STAT_W-1:0] stat_flushes,
`endif
  output logic              proto_error
);

  logic [2:0]        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] line_addr_q, line_addr_d;
  logic [DATA_W-1:0] line_data_q, line_data_d;
  logic [1:0]        new_state_q, new_state_d;
  logic              hit_q, hit_d;
  logic              flush_q, flush_d;
  logic              proto_err_q, proto_err_d;
  logic              line_valid;
  logic              lookup_hit;

  // A stored state of 11 counts as Invalid; only S and M can match
  assign line_valid = (line_state == LINE_SHARED) || (line_state == LINE_MODIFIED);
  assign lookup_hit = line_valid && (line_address == addr_q);

  // FSM next state, request capture, line snapshot and action decision
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    line_addr_d = line_addr_q;
    line_data_d = line_data_q;
    new_state_d = new_state_q;
    hit_d       = hit_q;
    flush_d     = flush_q;
    proto_err_d = proto_err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_valid) begin
          op_d    = bus_op;
          addr_d  = bus_address;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        line_addr_d = line_address;
        line_data_d = line_data;
        new_state_d = line_valid ? line_state : LINE_INVALID;
        hit_d       = lookup_hit;
        flush_d     = 1'b0;
        state_d     = ST_DONE;
        if (line_state == LINE_ILLEGAL) begin
          proto_err_d = 1'b1;
        end
        if (lookup_hit && (op_q != OP_NONE)) begin
          if (line_state == LINE_SHARED) begin
            if (op_q != OP_READ_MISS) begin
              new_state_d = LINE_INVALID;
              state_d     = ST_UPDATE;
            end
          end else begin
            flush_d     = 1'b1;
            state_d     = ST_WRITEBACK;
            new_state_d = (op_q == OP_READ_MISS) ? LINE_SHARED : LINE_INVALID;
            if (op_q == OP_INVALIDATE) begin
              proto_err_d = 1'b1;
            end
          end
        end
      end
      ST_WRITEBACK: begin
        if (mem_ack) begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and captured-value registers; reset clears everything
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      line_addr_q <= '0;
      line_data_q <= '0;
      new_state_q <= '0;
      hit_q       <= 1'b0;
      flush_q     <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      line_addr_q <= line_addr_d;
      line_data_q <= line_data_d;
      new_state_q <= new_state_d;
      hit_q       <= hit_d;
      flush_q     <= flush_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Ready is held low while reset is asserted even though the FSM sits in IDLE
  assign bus_ready        = reset_n && (state_q == ST_IDLE);
  assign bus_done         = (state_q == ST_DONE);
  assign bus_hit          = bus_done && hit_q;
  assign bus_flush        = bus_done && flush_q;
  assign line_write       = (state_q == ST_UPDATE);
  assign line_state_out   = new_state_q;
  assign line_address_out = line_addr_q;
  assign line_data_out    = line_data_q;
  assign mem_write        = (state_q == ST_WRITEBACK);
  assign mem_address      = line_addr_q;
  assign mem_data         = line_data_q;
  assign proto_error      = proto_err_q;

`ifdef SNOOP_STATS_EN
  sat_counter #(.WIDTH(STAT_W)) u_stat_hits (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (bus_hit),
    .clear   (1'b0),
    .value   (stat_hits)
  );

  sat_counter #(.WIDTH(STAT_W)) u_stat_flushes (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (bus_flush),
    .clear   (1'b0),
    .value   (stat_flushes)
  );
`endif

endmodule

// File: tb/tb_snoop_responder.sv
// Testbench for snoop_responder: directed snoop requests with expected
// completions, line writes and writebacks queued to a scoreboard that a
// separate monitor checks against the DUT outputs.
module tb_snoop_responder;

  logic       clock;
  logic       reset_n;
  logic       bus_valid;
  logic [1:0] bus_op;
  logic [2:0] bus_address;
  logic       bus_ready;
  logic       bus_done;
  logic       bus_hit;
  logic       bus_flush;
  logic [1:0] line_state;
  logic [2:0] line_address;
  logic [3:0] line_data;
  logic       line_write;
  logic [1:0] line_state_out;
  logic [2:0] line_address_out;
  logic [3:0] line_data_out;
  logic       mem_write;
  logic [2:0] mem_address;
  logic [3:0] mem_data;
  logic       mem_ack;
  logic       proto_error;
`ifdef SNOOP_STATS_EN
  logic [7:0] stat_hits;
  logic [7:0] stat_flushes;
`endif

  typedef struct {
    logic hit;
    logic flush;
    int   cyc;
  } done_exp_t;

  typedef struct {
    logic [1:0] st;
    logic [2:0] addr;
    logic [3:0] data;
  } lw_exp_t;

  typedef struct {
    logic [2:0] addr;
    logic [3:0] data;
  } mw_exp_t;

  done_exp_t done_q[$];
  lw_exp_t   lw_q[$];
  mw_exp_t   mw_q[$];

  int checks;
  int fails;
  int cycle_cnt;

  snoop_responder #(.ADDR_W(3), .DATA_W(4), .STAT_W(8)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .bus_valid        (bus_valid),
    .bus_op           (bus_op),
    .bus_address      (bus_address),
    .bus_ready        (bus_ready),
    .bus_done         (bus_done),
    .bus_hit          (bus_hit),
    .bus_flush        (bus_flush),
    .line_state       (line_state),
    .line_address     (line_address),
    .line_data        (line_data),
    .line_write       (line_write),
    .line_state_out   (line_state_out),
    .line_address_out (line_address_out),
    .line_data_out    (line_data_out),
    .mem_write        (mem_write),
    .mem_address      (mem_address),
    .mem_data         (mem_data),
    .mem_ack          (mem_ack),
`ifdef SNOOP_STATS_EN
    .stat_hits        (stat_hits),
    .stat_flushes     (stat_flushes),
`endif
    .proto_error      (proto_error)
  );

  // 10 ns clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Cycle counter used for latency checks
  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  // Overall time limit so the run can never hang
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: compare every DUT completion, line write and writeback cycle
  always @(negedge clock) begin
    if (reset_n) begin
      if (bus_done) begin
        if (done_q.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_done: got bus_done=1, expected no completion");
        end else begin
          done_exp_t e;
          e = done_q.pop_front();
          checkOutput("bus_hit", 32'(bus_hit), 32'(e.hit));
          checkOutput("bus_flush", 32'(bus_flush), 32'(e.flush));
          checkOutput("done_cycle", 32'(cycle_cnt), 32'(e.cyc));
        end
      end
      if (line_write) begin
        if (lw_q.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_line_write: got line_write=1, expected 0");
        end else begin
          lw_exp_t l;
          l = lw_q.pop_front();
          checkOutput("line_state_out", 32'(line_state_out), 32'(l.st));
          checkOutput("line_address_out", 32'(line_address_out), 32'(l.addr));
          checkOutput("line_data_out", 32'(line_data_out), 32'(l.data));
        end
      end
      if (mem_write) begin
        if (mw_q.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_mem_write: got mem_write=1, expected 0");
        end else begin
          checkOutput("mem_address", 32'(mem_address), 32'(mw_q[0].addr));
          checkOutput("mem_data", 32'(mem_data), 32'(mw_q[0].data));
          if (mem_ack) void'(mw_q.pop_front());
        end
      end
    end
  end

  // Issue one snoop request, queue its expectations and drive mem_ack.
  // ack_delay < 0 returns as soon as the writeback starts, without acking.
  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] addr,
                               input logic exp_hit, input logic exp_flush,
                               input int latency, input logic lw_en,
                               input logic [1:0] lw_state, input int ack_delay,
                               input logic scramble);
    int acc;
    int n;
    done_exp_t d;
    lw_exp_t   l;
    mw_exp_t   m;
    n = 0;
    while (!bus_ready && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    if (!bus_ready) begin
      checkOutput("ready_timeout", 32'(bus_ready), 32'd1);
    end
    bus_valid   = 1'b1;
    bus_op      = op;
    bus_address = addr;
    @(posedge clock); #1;
    acc       = cycle_cnt;
    bus_valid = 1'b0;
    bus_op    = 2'b00;
    d.hit = exp_hit; d.flush = exp_flush; d.cyc = acc + latency - 1;
    done_q.push_back(d);
    if (lw_en) begin
      l.st = lw_state; l.addr = line_address; l.data = line_data;
      lw_q.push_back(l);
    end
    if (exp_flush) begin
      m.addr = line_address; m.data = line_data;
      mw_q.push_back(m);
      @(posedge clock); #1;
      if (scramble) begin
        line_data    = ~line_data;
        line_address = line_address ^ 3'b111;
        line_state   = 2'b00;
      end
      n = 0;
      while (!mem_write && n < 10) begin
        @(posedge clock); #1;
        n++;
      end
      if (!mem_write) begin
        checkOutput("mem_write_timeout", 32'(mem_write), 32'd1);
      end
      if (ack_delay < 0) return;
      repeat (ack_delay) @(posedge clock);
      #1 mem_ack = 1'b1;
      @(posedge clock); #1;
      mem_ack = 1'b0;
    end
    n = 0;
    while (done_q.size() != 0 && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    if (done_q.size() != 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL done_timeout: got no bus_done, expected one");
      done_q.delete();
      lw_q.delete();
      mw_q.delete();
    end
  endtask

  task automatic setLine(input logic [1:0] st, input logic [2:0] addr,
                         input logic [3:0] data);
    line_state   = st;
    line_address = addr;
    line_data    = data;
  endtask

  initial begin
    checks = 0; fails = 0; cycle_cnt = 0;
    reset_n = 1'b0; bus_valid = 1'b0; bus_op = 2'b00; bus_address = 3'b000;
    mem_ack = 1'b0;
    setLine(2'b00, 3'b000, 4'h0);
    #22;
    // Reset values while reset is held
    checkOutput("reset_bus_ready", 32'(bus_ready), 32'd0);
    checkOutput("reset_bus_done", 32'(bus_done), 32'd0);
    checkOutput("reset_line_write", 32'(line_write), 32'd0);
    checkOutput("reset_mem_write", 32'(mem_write), 32'd0);
    checkOutput("reset_mem_address", 32'(mem_address), 32'd0);
    checkOutput("reset_mem_data", 32'(mem_data), 32'd0);
    checkOutput("reset_line_outs",
                32'({line_state_out, line_address_out, line_data_out}), 32'd0);
    checkOutput("reset_proto_error", 32'(proto_error), 32'd0);
    #10 reset_n = 1'b1;
    @(posedge clock); #1;
    checkOutput("ready_after_reset", 32'(bus_ready), 32'd1);

    $display("[TB] miss cases");
    setLine(2'b00, 3'b101, 4'h3);
    applyStimulus(2'b01, 3'b101, 1'b0, 1'b0, 2, 1'b0, 2'b00, 0, 1'b0);
    setLine(2'b01, 3'b010, 4'h6);
    applyStimulus(2'b01, 3'b011, 1'b0, 1'b0, 2, 1'b0, 2'b00, 0, 1'b0);
    applyStimulus(2'b11, 3'b110, 1'b0, 1'b0, 2, 1'b0, 2'b00, 0, 1'b0);

    $display("[TB] shared hits");
    applyStimulus(2'b10, 3'b010, 1'b1, 1'b0, 3, 1'b1, 2'b00, 0, 1'b0);
    applyStimulus(2'b01, 3'b010, 1'b1, 1'b0, 2, 1'b0, 2'b00, 0, 1'b0);
    applyStimulus(2'b11, 3'b010, 1'b1, 1'b0, 3, 1'b1, 2'b00, 0, 1'b0);

    $display("[TB] modified writebacks");
    setLine(2'b10, 3'b011, 4'b1010);
    applyStimulus(2'b01, 3'b011, 1'b1, 1'b1, 7, 1'b1, 2'b01, 3, 1'b1);
    setLine(2'b10, 3'b100, 4'b1100);
    applyStimulus(2'b10, 3'b100, 1'b1, 1'b1, 4, 1'b1, 2'b00, 0, 1'b0);
    checkOutput("proto_error_clean", 32'(proto_error), 32'd0);

    $display("[TB] protocol error");
    setLine(2'b10, 3'b111, 4'b0011);
    applyStimulus(2'b11, 3'b111, 1'b1, 1'b1, 5, 1'b1, 2'b00, 1, 1'b0);
    checkOutput("proto_error_set", 32'(proto_error), 32'd1);
    setLine(2'b00, 3'b001, 4'h0);
    applyStimulus(2'b01, 3'b001, 1'b0, 1'b0, 2, 1'b0, 2'b00, 0, 1'b0);
    checkOutput("proto_error_sticky", 32'(proto_error), 32'd1);

    $display("[TB] reset during writeback");
    setLine(2'b10, 3'b110, 4'b1001);
    applyStimulus(2'b01, 3'b110, 1'b1, 1'b1, 4, 1'b1, 2'b01, -1, 1'b0);
    checkOutput("wb_in_progress", 32'(mem_write), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("reset_drops_mem_write", 32'(mem_write), 32'd0);
    checkOutput("reset_mid_ready", 32'(bus_ready), 32'd0);
    checkOutput("reset_mid_proto", 32'(proto_error), 32'd0);
    checkOutput("reset_mid_line_write", 32'(line_write), 32'd0);
    done_q.delete();
    lw_q.delete();
    mw_q.delete();
    @(posedge clock); #3;
    reset_n = 1'b1;
    @(posedge clock); #1;
    checkOutput("ready_after_mid_reset", 32'(bus_ready), 32'd1);
    checkOutput("proto_after_mid_reset", 32'(proto_error), 32'd0);
    repeat (5) @(posedge clock);
    #1;

`ifdef SNOOP_STATS_EN
    $display("[TB] statistics saturation");
    checkOutput("stat_hits_reset", 32'(stat_hits), 32'd0);
    checkOutput("stat_flushes_reset", 32'(stat_flushes), 32'd0);
    setLine(2'b10, 3'b011, 4'b1010);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(2'b01, 3'b011, 1'b1, 1'b1, 4, 1'b1, 2'b01, 0, 1'b0);
      if (i == 9) begin
        checkOutput("stat_hits_10", 32'(stat_hits), 32'd10);
        checkOutput("stat_flushes_10", 32'(stat_flushes), 32'd10);
      end
    end
    checkOutput("stat_hits_sat", 32'(stat_hits), 32'd255);
    checkOutput("stat_flushes_sat", 32'(stat_flushes), 32'd255);
`endif

    $display("[TB] illegal line state");
    setLine(2'b11, 3'b010, 4'h5);
    applyStimulus(2'b01, 3'b010, 1'b0, 1'b0, 2, 1'b0, 2'b00, 0, 1'b0);
    checkOutput("proto_error_illegal_state", 32'(proto_error), 32'd1);

    repeat (3) @(posedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
